// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, optional even/odd parity,
// 1/1.5/2 stop bits, with a one-entry holding register for back-to-back frames.
module uart_tx_cfg #(
  parameter int unsigned NB_DATA_MAX = 8,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_s_tick,
  input  logic                   i_tx_valid,
  input  logic [NB_DATA_MAX-1:0] i_tx_data,
  input  logic [1:0]             i_data_bits,
  input  logic [1:0]             i_parity_mode,
  input  logic [1:0]             i_stop_mode,
  output logic                   o_tx_ready,
  output logic                   o_busy,
  output logic                   o_tx_done_tick,
  output logic                   o_tx
);

  localparam int unsigned CntW = $clog2(2 * OVERSAMPLE);
  // Terminal counts (length - 1) for each phase length.
  localparam logic [CntW-1:0] LastBit    = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] LastStop15 = CntW'((3 * OVERSAMPLE) / 2 - 1);
  localparam logic [CntW-1:0] LastStop2  = CntW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [NB_DATA_MAX-1:0] shift_q, shift_d;
  logic [1:0]             nbits_q, nbits_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic [1:0]             stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;

  logic                   hold_full_q, hold_full_d;
  logic [NB_DATA_MAX-1:0] hold_data_q;
  logic [1:0]             hold_bits_q, hold_par_q, hold_stop_q;

  logic                   hs, load, phase_end;
  logic [CntW-1:0]        phase_last;
  logic [NB_DATA_MAX-1:0] hold_mask;
  logic [3:0]             hold_len;
  logic                   hold_par_bit;

  assign hs = i_tx_valid & ~hold_full_q;

  // Parity of the queued entry, masked to its own data length.
  always_comb begin
    hold_len = 4'd5 + {2'b00, hold_bits_q};
    hold_mask = '0;
    for (int unsigned i = 0; i < NB_DATA_MAX; i++) begin
      hold_mask[i] = (i < {28'd0, hold_len});
    end
    hold_par_bit = (^(hold_data_q & hold_mask)) ^ (hold_par_q == 2'b10);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    load      = 1'b0;

    phase_last = LastBit;
    if (state_q == StStop) begin
      case (stop_q)
        2'b00:   phase_last = LastBit;
        2'b01:   phase_last = LastStop15;
        default: phase_last = LastStop2;
      endcase
    end
    phase_end = i_s_tick && (cnt_q == phase_last);

    if (state_q != StIdle && i_s_tick) begin
      cnt_d = phase_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      StIdle:  load = hold_full_q;
      StStart: if (phase_end) state_d = StData;
      StData: begin
        if (phase_end) begin
          shift_d = shift_q >> 1;
          // Last active bit index is 4 + nbits.
          if (bit_q == {1'b1, nbits_q}) begin
            bit_d   = '0;
            state_d = par_en_q ? StParity : StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      StParity: if (phase_end) state_d = StStop;
      StStop: begin
        if (phase_end) begin
          done_d = 1'b1;
          if (hold_full_q) load = 1'b1;
          else             state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      state_d   = StStart;
      cnt_d     = '0;
      bit_d     = '0;
      shift_d   = hold_data_q;
      nbits_d   = hold_bits_q;
      par_en_d  = (hold_par_q == 2'b01) || (hold_par_q == 2'b10);
      par_bit_d = hold_par_bit;
      stop_d    = hold_stop_q;
    end

    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase

    hold_full_d = load ? 1'b0 : (hs ? 1'b1 : hold_full_q);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      nbits_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      stop_q      <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_bits_q <= '0;
      hold_par_q  <= '0;
      hold_stop_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      nbits_q     <= nbits_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      stop_q      <= stop_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      hold_full_q <= hold_full_d;
      if (hs) begin
        hold_data_q <= i_tx_data;
        hold_bits_q <= i_data_bits;
        hold_par_q  <= i_parity_mode;
        hold_stop_q <= i_stop_mode;
      end
    end
  end

  assign o_tx_ready     = ~hold_full_q;
  assign o_busy         = (state_q != StIdle);
  assign o_tx_done_tick = done_q;
  assign o_tx           = tx_q;

endmodule
